// File: rtl/h14tx_pkg.sv
// Shared types and the round-robin search used by the h14tx pixel/DMA/OSD arbiters.
package h14tx_pkg;

    localparam int RR_MAX_SRC = 8;

    typedef logic [2:0][7:0] pixel_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_result_t;

    // First set bit of req at or after base, wrapping modulo n (n in 2..8).
    function automatic rr_result_t rr_pick(
        input logic [RR_MAX_SRC-1:0] req,
        input logic [2:0]            base,
        input int                    n
    );
        rr_result_t res;
        int         cand;
        res = '0;
        for (int k = 0; k < RR_MAX_SRC; k++) begin
            cand = (int'(base) + k) % n;
            if (k < n && !res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = 3'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/h14tx_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after base, wrapping.
module h14tx_rr_picker
    import h14tx_pkg::*;
#(
    parameter int NumSrc = 4
) (
    input  logic [NumSrc-1:0]         req,
    input  logic [$clog2(NumSrc)-1:0] base,
    output logic [$clog2(NumSrc)-1:0] idx,
    output logic                      found
);

    localparam int IdxW = $clog2(NumSrc);

    logic [RR_MAX_SRC-1:0] req_wide;
    logic [2:0]            base_wide;
    rr_result_t            res;

    genvar gi;
    generate
        for (gi = 0; gi < RR_MAX_SRC; gi++) begin : g_req
            if (gi < NumSrc) begin : g_live
                assign req_wide[gi] = req[gi];
            end else begin : g_pad
                assign req_wide[gi] = 1'b0;
            end
        end
    endgenerate

    assign base_wide = 3'(base);
    assign res       = rr_pick(req_wide, base_wide, NumSrc);
    assign idx       = IdxW'(res.idx);
    assign found     = res.found;

endmodule

// File: rtl/h14tx_frame_arbiter.sv
// Frame-boundary arbiter sharing the h14tx_rgb pixel path between NumSrc sources.
// Optional statistics outputs (switch_cnt, starve) are enabled by H14TX_ARB_STATS_EN.
module h14tx_frame_arbiter
    import h14tx_pkg::*;
#(
    parameter int NumSrc       = 4,
    parameter int BitWidth     = 11,
    parameter int BitHeight    = 10,
    parameter int FrameWidth   = 1650,
    parameter int FrameHeight  = 750,
    parameter int ActiveWidth  = 1280,
    parameter int ActiveHeight = 720,
    parameter int Quota        = 2
) (
    input  logic                      pixel_clk,
    input  logic                      rst,
    input  logic [BitWidth-1:0]       x,
    input  logic [BitHeight-1:0]      y,
    input  logic [NumSrc-1:0]         req,
    input  logic [NumSrc*24-1:0]      src_rgb,
    output logic [NumSrc-1:0]         grant,
    output logic                      grant_valid,
    output logic [$clog2(NumSrc)-1:0] owner_idx,
    output logic                      frame_start,
    output logic [23:0]               rgb
`ifdef H14TX_ARB_STATS_EN
    ,
    output logic [15:0]               switch_cnt,
    output logic                      starve
`endif
);

    localparam int                   IdxW    = $clog2(NumSrc);
    localparam logic [IdxW-1:0]      LastIdx = IdxW'(NumSrc - 1);
    localparam logic [BitWidth-1:0]  XLast   = BitWidth'(FrameWidth - 1);
    localparam logic [BitHeight-1:0] YLast   = BitHeight'(FrameHeight - 1);
    localparam logic [BitWidth-1:0]  XActive = BitWidth'(ActiveWidth);
    localparam logic [BitHeight-1:0] YActive = BitHeight'(ActiveHeight);
    // Quota==0 never preempts, so the counter simply parks at zero.
    localparam logic [15:0]          CntMax  = 16'((Quota > 0 ? Quota : 1) - 1);

    arb_state_e      state_reg, state_next;
    logic [IdxW-1:0] owner_reg, owner_next;
    logic [IdxW-1:0] last_reg, last_next;
    logic [15:0]     frame_cnt_reg, frame_cnt_next;
    logic            frame_start_reg;
    pixel_t          rgb_reg, rgb_next;

    logic            fb;
    logic            active;
    logic            others_pending;
    logic            release_own;
    logic [IdxW-1:0] pick_base;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;
    pixel_t          src_pix [NumSrc];

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == LastIdx) ? '0 : i + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NumSrc; gi++) begin : g_src
            assign src_pix[gi] = src_rgb[gi*24 +: 24];
            assign grant[gi]   = (state_reg == ARB_OWN) && (owner_reg == IdxW'(gi));
        end
    endgenerate

    assign fb     = (x == XLast) && (y == YLast);
    assign active = (x < XActive) && (y < YActive);

    // Searching from owner+1 leaves the owner as the last candidate on release.
    assign pick_base = (state_reg == ARB_IDLE) ? next_idx(last_reg) : next_idx(owner_reg);

    h14tx_rr_picker #(
        .NumSrc (NumSrc)
    ) u_picker (
        .req   (req),
        .base  (pick_base),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign others_pending = |(req & ~grant);
    assign release_own    = !req[owner_reg]
                          || ((Quota != 0) && (frame_cnt_reg == CntMax) && others_pending);

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        frame_cnt_next = frame_cnt_reg;
        if (fb) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_next     = ARB_OWN;
                        owner_next     = pick_idx;
                        frame_cnt_next = '0;
                    end
                end
                ARB_OWN: begin
                    if (release_own) begin
                        last_next      = owner_reg;
                        frame_cnt_next = '0;
                        if (pick_found) begin
                            owner_next = pick_idx;
                        end else begin
                            state_next = ARB_IDLE;
                            owner_next = '0;
                        end
                    end else if (frame_cnt_reg != CntMax) begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_next = ARB_IDLE;
                    owner_next = '0;
                end
            endcase
        end
    end

    assign rgb_next = (grant_valid && active) ? src_pix[owner_reg] : '0;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_reg       <= ARB_IDLE;
            owner_reg       <= '0;
            last_reg        <= LastIdx;
            frame_cnt_reg   <= '0;
            frame_start_reg <= 1'b0;
            rgb_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            last_reg        <= last_next;
            frame_cnt_reg   <= frame_cnt_next;
            frame_start_reg <= fb;
            rgb_reg         <= rgb_next;
        end
    end

    assign grant_valid = (state_reg == ARB_OWN);
    assign owner_idx   = owner_reg;
    assign frame_start = frame_start_reg;
    assign rgb         = rgb_reg;

`ifdef H14TX_ARB_STATS_EN
    localparam int               StarveLimit = (NumSrc - 1) * (Quota > 0 ? Quota : 1) + 1;
    localparam int               WaitW       = $clog2(StarveLimit + 2);
    localparam logic [WaitW-1:0] WaitLimit   = WaitW'(StarveLimit);
    localparam logic [WaitW-1:0] WaitSat     = WaitW'(StarveLimit + 1);

    logic              owner_change;
    logic [15:0]       switch_cnt_reg;
    logic [NumSrc-1:0] starving;

    assign owner_change = fb && (((state_reg == ARB_IDLE) && pick_found)
                               || ((state_reg == ARB_OWN) && release_own));

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            switch_cnt_reg <= '0;
        end else if (owner_change) begin
            switch_cnt_reg <= switch_cnt_reg + 16'd1;
        end
    end

    // Per-source count of frame boundaries crossed while requesting but not granted.
    generate
        for (gi = 0; gi < NumSrc; gi++) begin : g_wait
            logic [WaitW-1:0] wait_cnt_reg;
            logic             granted_next;

            assign granted_next = (state_next == ARB_OWN) && (owner_next == IdxW'(gi));

            always_ff @(posedge pixel_clk) begin
                if (rst || !req[gi]) begin
                    wait_cnt_reg <= '0;
                end else if (fb) begin
                    if (granted_next) begin
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg != WaitSat) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
            end

            assign starving[gi] = (wait_cnt_reg > WaitLimit);
        end
    endgenerate

    assign switch_cnt = switch_cnt_reg;
    assign starve     = |starving;
`endif

endmodule

// File: tb/tb_h14tx_frame_arbiter.sv
// Randomized bench for h14tx_frame_arbiter on a shrunken frame, checked against a behavioural model.
module tb_h14tx_frame_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int BH = 3;
    localparam int FW = 8;
    localparam int FH = 5;
    localparam int AW = 6;
    localparam int AH = 4;
    localparam int Q  = 2;
    localparam int STARVE_LIM = (N - 1) * ((Q > 0) ? Q : 1) + 1;

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] x = '0;
    logic [BH-1:0] y = '0;
    logic [N-1:0]  req = '0;
    logic [N*24-1:0] src_rgb = '0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [1:0]    owner_idx;
    logic          frame_start;
    logic [23:0]   rgb;
`ifdef H14TX_ARB_STATS_EN
    logic [15:0]   switch_cnt;
    logic          starve;
`endif

    always #5 pixel_clk = ~pixel_clk;

    h14tx_frame_arbiter #(
        .NumSrc(N), .BitWidth(BW), .BitHeight(BH), .FrameWidth(FW), .FrameHeight(FH),
        .ActiveWidth(AW), .ActiveHeight(AH), .Quota(Q)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .req         (req),
        .src_rgb     (src_rgb),
        .grant       (grant),
        .grant_valid (grant_valid),
        .owner_idx   (owner_idx),
        .frame_start (frame_start),
        .rgb         (rgb)
`ifdef H14TX_ARB_STATS_EN
        ,
        .switch_cnt  (switch_cnt),
        .starve      (starve)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: owner -1 means nobody holds the link.
    int          m_owner = -1;
    int          m_last  = N - 1;
    int          m_held  = 0;
    int          m_sw    = 0;
    int          m_wait [N];
    logic [23:0] m_rgb   = '0;
    bit          m_fs    = 1'b0;

    int cx = 0;
    int cy = 0;
    bit checking = 1'b0;
    bit phase_a = 1'b0;
    bit seq_armed = 1'b0;
    int seq_pos = 0;
    int owner_seq [7] = '{0, 0, 2, 2, 0, 0, 2};
    bit phase_d = 1'b0;
    bit d_armed = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int base, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [N-1:0] g_exp;
        bit starve_exp;
        g_exp = '0;
        if (m_owner >= 0) g_exp[m_owner] = 1'b1;
        check_eq("grant", 32'(grant), 32'(g_exp));
        check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check_eq("owner_idx", 32'(owner_idx), (m_owner >= 0) ? m_owner : 0);
        check_eq("frame_start", 32'(frame_start), 32'(m_fs));
        check_eq("rgb", 32'(rgb), 32'(m_rgb));
        if (seq_armed) begin
            check_eq("owner_seq", 32'(owner_idx), owner_seq[seq_pos]);
            seq_pos++;
            seq_armed = 1'b0;
        end
        if (d_armed) begin
            check_eq("src0_after_rst", 32'(grant), 32'h1);
            d_armed = 1'b0;
        end
        starve_exp = 1'b0;
        for (int i = 0; i < N; i++) if (m_wait[i] > STARVE_LIM) starve_exp = 1'b1;
`ifdef H14TX_ARB_STATS_EN
        check_eq("switch_cnt", 32'(switch_cnt), 32'(m_sw[15:0]));
        check_eq("starve", 32'(starve), 32'(starve_exp));
`endif
    endtask

    task automatic model_edge();
        bit fb;
        bit others;
        int nxt;
        fb = (int'(x) == FW - 1) && (int'(y) == FH - 1);
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_held = 0; m_sw = 0;
            m_rgb = '0; m_fs = 1'b0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            return;
        end
        m_rgb = (m_owner >= 0 && int'(x) < AW && int'(y) < AH) ? src_rgb[m_owner*24 +: 24] : 24'd0;
        m_fs = fb;
        if (fb) begin
            nxt = m_owner;
            if (m_owner < 0) begin
                nxt = pick(m_last, req);
            end else begin
                others = 1'b0;
                for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1'b1;
                if (!req[m_owner] || (Q != 0 && m_held >= Q && others)) begin
                    m_last = m_owner;
                    nxt = pick(m_owner, req);
                end else begin
                    m_held++;
                end
            end
            if (nxt != m_owner) begin
                m_sw++;
                m_held = 1;
            end
            m_owner = nxt;
            if (phase_a && seq_pos < 7) seq_armed = 1'b1;
            if (phase_d) d_armed = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (!req[i]) m_wait[i] = 0;
            else if (fb) m_wait[i] = (m_owner == i) ? 0 : m_wait[i] + 1;
        end
    endtask

    task automatic drive_cycle(input bit rst_v, input bit oor, input logic [N-1:0] req_v);
        @(negedge pixel_clk);
        if (checking) check_outputs();
        rst = rst_v;
        req = req_v;
        if (oor) begin
            x = 4'd15;
            y = 3'd7;
        end else begin
            x = BW'(cx);
            y = BH'(cy);
            cx++;
            if (cx == FW) begin
                cx = 0;
                cy = (cy + 1) % FH;
            end
        end
        for (int i = 0; i < N; i++) src_rgb[i*24 +: 24] = 24'($urandom);
        model_edge();
        checking = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) m_wait[i] = 0;

        drive_cycle(1'b1, 1'b0, 4'b0000);
        drive_cycle(1'b1, 1'b0, 4'b0101);

        // Two requesters held: quota alternation 0,0,2,2,...
        phase_a = 1'b1;
        repeat (7 * FW * FH) drive_cycle(1'b0, 1'b0, 4'b0101);
        phase_a = 1'b0;

        // Random request churn with a mid-frame reset and an out-of-range x/y burst.
        r = 4'b0101;
        for (int c = 0; c < 80 * FW * FH; c++) begin
            if ($urandom_range(0, 24) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) r = '0;
            drive_cycle(c == 1234, (c >= 2000 && c < 2015), r);
        end

        // Owner 3 holding, reset mid-frame: src0 must win at the next boundary.
        repeat (3 * FW * FH) drive_cycle(1'b0, 1'b0, 4'b1000);
        while (!(cx == 4 && cy == 2)) drive_cycle(1'b0, 1'b0, 4'b1000);
        drive_cycle(1'b1, 1'b0, 4'b1001);
        phase_d = 1'b1;
        repeat (FW * FH + 2) drive_cycle(1'b0, 1'b0, 4'b1001);
        phase_d = 1'b0;
        repeat (2 * FW * FH) drive_cycle(1'b0, 1'b0, 4'b1001);

        drive_cycle(1'b0, 1'b0, 4'b1001);
        check_eq("owner_seq_count", 32'(seq_pos), 32'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
